regfile_2r1w: RTL and testbench

Parametrised multi-entry successor to the single 4-bit load register. It is a DEPTH x WIDTH register file with one write port and two independent read ports. Reads are registered with 1-cycle latency, write-to-read bypass is selectable, and the block supports a synchronous clear-all and an optional hardwired-zero entry 0. It sits beside datapath units as their operand store, replacing banks of discrete load registers.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 68 ++++++
 rtl/regfile_2r1w.sv | 78 +++++++
 tb/tb_regfile_2r1w.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: address sizing helper
// and the read-value source encoding used by each read port.
package regfile_pkg;

    typedef enum logic [1:0] {
        RD_OOR  = 2'd0,
        RD_ZERO = 2'd1,
        RD_BYP  = 2'd2,
        RD_MEM  = 2'd3
    } rd_sel_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: selects the read value by priority and captures it
// with a valid pulse one cycle after the request.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    parameter int ADDR_W  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DEPTH-1:0][WIDTH-1:0]     mem_i,
    input  logic                            clr_i,
    input  logic                            wr_en_i,
    input  logic [ADDR_W-1:0]               waddr_i,
    input  logic [WIDTH-1:0]                wdata_i,
    input  logic                            re_i,
    input  logic [ADDR_W-1:0]               raddr_i,
    output logic [WIDTH-1:0]                rdata_o,
    output logic                            rvalid_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    rd_sel_e            sel;
    logic [WIDTH-1:0]   rdata_d;
    logic [WIDTH-1:0]   rdata_q;
    logic               rvalid_q;

    // A clear in flight reads as zero when bypassing, so it shares the RD_ZERO source.
    always_comb begin
        sel = RD_MEM;
        if ({1'b0, raddr_i} >= DEPTH_L)
            sel = RD_OOR;
        else if (ZERO_R0 != 0 && raddr_i == '0)
            sel = RD_ZERO;
        else if (BYPASS != 0 && clr_i)
            sel = RD_ZERO;
        else if (BYPASS != 0 && wr_en_i && waddr_i == raddr_i)
            sel = RD_BYP;
    end

    always_comb begin
        rdata_d = '0;
        case (sel)
            RD_BYP:  rdata_d = wdata_i;
            RD_MEM:  rdata_d = mem_i[raddr_i];
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i)
                rdata_q <= rdata_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH flop-based register file with one write port, two registered
// read ports, synchronous clear-all and optional hardwired-zero entry 0.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                        wr_en;
    logic                        err_d;
    logic                        err_q;

    function automatic logic oor(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= DEPTH_L;
    endfunction

    assign wr_en = we && !oor(waddr) && !clr && !(ZERO_R0 != 0 && waddr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= '0;
        else if (clr)
            mem_q <= '0;
        else if (wr_en)
            mem_q[waddr] <= wdata;
    end

    assign err_d = (we && oor(waddr)) || (re_a && oor(raddr_a)) || (re_b && oor(raddr_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;

    regfile_rd_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0), .ADDR_W(ADDR_W)
    ) u_rd_a (
        .clk(clk), .rst_n(rst_n), .mem_i(mem_q), .clr_i(clr), .wr_en_i(wr_en),
        .waddr_i(waddr), .wdata_i(wdata), .re_i(re_a), .raddr_i(raddr_a),
        .rdata_o(rdata_a), .rvalid_o(rvalid_a)
    );

    regfile_rd_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0), .ADDR_W(ADDR_W)
    ) u_rd_b (
        .clk(clk), .rst_n(rst_n), .mem_i(mem_q), .clr_i(clr), .wr_en_i(wr_en),
        .waddr_i(waddr), .wdata_i(wdata), .re_i(re_b), .raddr_i(raddr_b),
        .rdata_o(rdata_b), .rvalid_o(rvalid_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives three register-file configurations with shared stimulus and compares
// every output each cycle against an array-based reference model.
module tb_regfile_2r1w;

    localparam int NI = 3;
    localparam int DEP [NI] = '{8, 8, 6};
    localparam int BY  [NI] = '{1, 0, 1};
    localparam int ZR  [NI] = '{0, 1, 0};

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [2:0] raddr_a;
    logic       re_b;
    logic [2:0] raddr_b;

    logic [7:0] rd_a [NI];
    logic [7:0] rd_b [NI];
    logic       vl_a [NI];
    logic       vl_b [NI];
    logic       er   [NI];

    int m_mem [NI][8];
    int e_ra [NI];
    int e_rb [NI];
    int e_va [NI];
    int e_vb [NI];
    int e_er [NI];

    int checks;
    int failures;

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) u_byp (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rd_a[0]), .rvalid_a(vl_a[0]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rd_b[0]), .rvalid_b(vl_b[0]), .err(er[0])
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .BYPASS(0), .ZERO_R0(1)) u_nbz (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rd_a[1]), .rvalid_a(vl_a[1]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rd_b[1]), .rvalid_b(vl_b[1]), .err(er[1])
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .BYPASS(1), .ZERO_R0(0)) u_d6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rd_a[2]), .rvalid_a(vl_a[2]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rd_b[2]), .rvalid_b(vl_b[2]), .err(er[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit wr_eff(input int k);
        return we && int'(waddr) < DEP[k] && !clr && !(ZR[k] != 0 && waddr == 3'd0);
    endfunction

    function automatic int mread(input int k, input int a);
        if (a >= DEP[k]) return 0;
        if (ZR[k] != 0 && a == 0) return 0;
        if (BY[k] != 0 && clr) return 0;
        if (BY[k] != 0 && wr_eff(k) && int'(waddr) == a) return int'(wdata);
        return m_mem[k][a];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (re_a) e_ra[k] = mread(k, int'(raddr_a));
            if (re_b) e_rb[k] = mread(k, int'(raddr_b));
            e_va[k] = re_a ? 1 : 0;
            e_vb[k] = re_b ? 1 : 0;
            e_er[k] = ((we && int'(waddr) >= DEP[k]) || (re_a && int'(raddr_a) >= DEP[k]) ||
                       (re_b && int'(raddr_b) >= DEP[k])) ? 1 : 0;
            if (clr) begin
                for (int i = 0; i < 8; i++) m_mem[k][i] = 0;
            end else if (wr_eff(k)) begin
                m_mem[k][waddr] = int'(wdata);
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("i%0d_rdata_a", k), 32'(rd_a[k]), e_ra[k]);
            check($sformatf("i%0d_rvalid_a", k), 32'(vl_a[k]), e_va[k]);
            check($sformatf("i%0d_rdata_b", k), 32'(rd_b[k]), e_rb[k]);
            check($sformatf("i%0d_rvalid_b", k), 32'(vl_b[k]), e_vb[k]);
            check($sformatf("i%0d_err", k), 32'(er[k]), e_er[k]);
        end
    endtask

    task automatic drive(input bit c, input bit w, input int wa, input int wd,
                         input bit ra_en, input int ra, input bit rb_en, input int rb);
        clr     = c;
        we      = w;
        waddr   = 3'(wa);
        wdata   = 8'(wd);
        re_a    = ra_en;
        raddr_a = 3'(ra);
        re_b    = rb_en;
        raddr_b = 3'(rb);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Drops rst_n between edges and releases it well before the next edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = 0;
            e_ra[k] = 0; e_rb[k] = 0; e_va[k] = 0; e_vb[k] = 0; e_er[k] = 0;
        end
        #1;
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic readback();
        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 0, 0, 1, a, 1, 7 - a);
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        async_reset();

        // Load, hold and reload
        drive(0, 1, 3, 8'h05, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 3, 0, 0);     step();
        check("s1_load_rd", 32'(rd_a[0]), 32'h05);
        check("s1_load_vld", 32'(vl_a[0]), 32'h1);
        drive(0, 1, 3, 8'h09, 0, 3, 0, 0); step();
        check("s1_hold_rd", 32'(rd_a[0]), 32'h05);
        check("s1_hold_vld", 32'(vl_a[0]), 32'h0);
        drive(0, 0, 0, 0, 1, 3, 0, 0);     step();
        check("s1_reload_rd", 32'(rd_a[0]), 32'h09);

        // Same-cycle write and read of one address
        drive(0, 1, 2, 8'h0C, 1, 2, 1, 2); step();
        check("s2_byp_a", 32'(rd_a[0]), 32'h0C);
        check("s2_byp_b", 32'(rd_b[0]), 32'h0C);
        check("s2_nobyp_a", 32'(rd_a[1]), 32'h00);
        drive(0, 0, 0, 0, 1, 2, 0, 0);     step();
        check("s2_nobyp_next", 32'(rd_a[1]), 32'h0C);

        // Clear beats a same-cycle write
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, i, 8'h10 + i, 0, 0, 0, 0); step();
        end
        drive(1, 1, 5, 8'hAA, 1, 5, 0, 0); step();
        check("s3_clr_byp", 32'(rd_a[0]), 32'h00);
        check("s3_clr_nobyp", 32'(rd_a[1]), 32'h15);
        readback();

        // Hardwired-zero entry 0
        drive(0, 1, 1, 8'h11, 0, 0, 0, 0); step();
        drive(0, 1, 0, 8'hFF, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0, 1, 1);     step();
        check("s4_r0_zero", 32'(rd_a[1]), 32'h00);
        check("s4_r1_kept", 32'(rd_b[1]), 32'h11);
        check("s4_err", 32'(er[1]), 32'h0);

        // Out-of-range accesses on the 6-entry instance
        drive(0, 1, 7, 8'h77, 0, 0, 0, 0); step();
        check("s5_wr_err", 32'(er[2]), 32'h1);
        check("s5_wr_err_d8", 32'(er[0]), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 1, 6);     step();
        check("s5_rd_data", 32'(rd_b[2]), 32'h00);
        check("s5_rd_vld", 32'(vl_b[2]), 32'h1);
        check("s5_rd_err", 32'(er[2]), 32'h1);
        readback();

        // Asynchronous reset with a read in flight
        drive(0, 1, 4, 8'h33, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 4, 0, 0);     step();
        check("s6_pre_rd", 32'(rd_a[0]), 32'h33);
        drive(0, 0, 0, 0, 1, 4, 0, 0);
        async_reset();
        check("s6_rst_rd", 32'(rd_a[0]), 32'h00);
        check("s6_rst_vld", 32'(vl_a[0]), 32'h0);
        readback();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) == 0, 1'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(0, 7)),
                  1'($urandom), int'($urandom_range(0, 7)));
            step();
            if (n == 200) async_reset();
        end
        readback();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
